// File: rtl/binarize_frame_ctrl.sv
// Per-frame sequencer for the quadrant-threshold binarizer: scans the grey frame,
// derives four quadrant thresholds (mean + offset, saturated), then hands SRAM to the converter.
module binarize_frame_ctrl #(
    parameter int ROWS     = 160,
    parameter int COLS     = 80,
    parameter int HALF_ROW = 80,
    parameter int HALF_COL = 40,
    parameter int SUM_W    = 21
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [19:0] i_begin_addr,
    input  logic [7:0]  i_offset,
    input  logic [15:0] i_sram_rdata,
    output logic [19:0] o_sram_addr,
    input  logic [19:0] i_conv_sram_addr,
    output logic        o_conv_start,
    input  logic        i_conv_finished,
    output logic [7:0]  o_threshold1,
    output logic [7:0]  o_threshold2,
    output logic [7:0]  o_threshold3,
    output logic [7:0]  o_threshold4,
    output logic        o_busy,
    output logic        o_done
);

    localparam int DIVISOR = 2 * HALF_ROW * HALF_COL;
    localparam int REM_W   = $clog2(DIVISOR);
    localparam int REM_SW  = REM_W + 1;
    localparam int ROW_W   = $clog2(ROWS);
    localparam int COL_W   = $clog2(COLS);
    localparam int DCNT_W  = $clog2(SUM_W);

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_HALF  = ROW_W'(HALF_ROW);
    localparam logic [COL_W-1:0]  COL_HALF  = COL_W'(HALF_COL);
    localparam logic [REM_SW-1:0] DIVISOR_L = REM_SW'(DIVISOR);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(SUM_W - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SCAN       = 3'd1;
    localparam logic [2:0] S_DIV        = 3'd2;
    localparam logic [2:0] S_CONV_START = 3'd3;
    localparam logic [2:0] S_CONV_WAIT  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [19:0]       addr_q, addr_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [SUM_W-1:0]  sum_q [4];
    logic [SUM_W-1:0]  sum_d [4];
    logic [1:0]        dq_q, dq_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [SUM_W-1:0]  quo_q, quo_d;
    logic [7:0]        thr_q [4];
    logic [7:0]        thr_d [4];
    logic              wait_first_q, wait_first_d;
    logic              done_q, done_d;

    logic [8:0]        pix_sum;
    logic [1:0]        scan_quad;
    logic [REM_SW-1:0] rem_shift;
    logic              rem_ge;
    logic [REM_W-1:0]  rem_next;
    logic [SUM_W-1:0]  quo_next;

    // Mean plus signed offset at 10 bits, so neither end can wrap before the clamp.
    function automatic logic [7:0] offset_clamp(input logic [7:0] mean, input logic [7:0] offset);
        logic [9:0] total;
        total = {2'b00, mean} + {{2{offset[7]}}, offset};
        if (total[9])      return 8'd0;
        else if (total[8]) return 8'hFF;
        else               return total[7:0];
    endfunction

    assign pix_sum   = {1'b0, i_sram_rdata[15:8]} + {1'b0, i_sram_rdata[7:0]};
    assign scan_quad = {row_q >= ROW_HALF, col_q >= COL_HALF};

    // Restoring division: the dividend is shifted out of quo_q MSB-first while quotient bits enter at the LSB.
    assign rem_shift = {rem_q, quo_q[SUM_W-1]};
    assign rem_ge    = (rem_shift >= DIVISOR_L);
    assign rem_next  = rem_ge ? REM_W'(rem_shift - DIVISOR_L) : rem_shift[REM_W-1:0];
    assign quo_next  = {quo_q[SUM_W-2:0], rem_ge};

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case leaves it unassigned (no latches).
        state_d      = state_q;
        addr_d       = addr_q;
        row_d        = row_q;
        col_d        = col_q;
        sum_d        = sum_q;
        dq_d         = dq_q;
        dcnt_d       = dcnt_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        thr_d        = thr_q;
        wait_first_d = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d  = i_begin_addr;
                    row_d   = '0;
                    col_d   = '0;
                    for (int q = 0; q < 4; q++) sum_d[q] = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                sum_d[scan_quad] = sum_q[scan_quad] + SUM_W'(pix_sum);
                addr_d = addr_q + 20'd1;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
                if (row_q == ROW_LAST && col_q == COL_LAST) begin
                    // The final word belongs to BR, so the TL sum is already complete.
                    quo_d   = sum_q[0];
                    rem_d   = '0;
                    dcnt_d  = '0;
                    dq_d    = 2'd0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_d  = rem_next;
                quo_d  = quo_next;
                dcnt_d = dcnt_q + 1'b1;
                if (dcnt_q == DCNT_LAST) begin
                    thr_d[dq_q] = offset_clamp(quo_next[7:0], i_offset);
                    rem_d       = '0;
                    dcnt_d      = '0;
                    if (dq_q == 2'd3) begin
                        state_d = S_CONV_START;
                    end else begin
                        dq_d  = dq_q + 2'd1;
                        quo_d = sum_q[dq_q + 2'd1];
                    end
                end
            end
            S_CONV_START: begin
                wait_first_d = 1'b1;
                state_d      = S_CONV_WAIT;
            end
            S_CONV_WAIT: begin
                // A finished level left over from the previous frame is not trusted on the first cycle.
                if (!wait_first_q && i_conv_finished) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the small sum/threshold arrays are plain flops, not RAM, so they are reset like any register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            dq_q         <= '0;
            dcnt_q       <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            wait_first_q <= 1'b0;
            done_q       <= 1'b0;
            for (int q = 0; q < 4; q++) begin
                sum_q[q] <= '0;
                thr_q[q] <= 8'd128;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
            state_q      <= state_d;
            addr_q       <= addr_d;
            row_q        <= row_d;
            col_q        <= col_d;
            dq_q         <= dq_d;
            dcnt_q       <= dcnt_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            wait_first_q <= wait_first_d;
            done_q       <= done_d;
            sum_q        <= sum_d;
            thr_q        <= thr_d;
        end
    end

    always_comb begin
        o_sram_addr = 20'd0;
        if (state_q == S_SCAN)
            o_sram_addr = addr_q;
        else if (state_q == S_CONV_START || state_q == S_CONV_WAIT)
            o_sram_addr = i_conv_sram_addr;
    end

    assign o_conv_start = (state_q == S_CONV_START);
    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = done_q;
    assign o_threshold1 = thr_q[0];
    assign o_threshold2 = thr_q[1];
    assign o_threshold3 = thr_q[2];
    assign o_threshold4 = thr_q[3];

endmodule

// File: tb/tb_binarize_frame_ctrl.sv
// Directed bench for binarize_frame_ctrl: a behavioural SRAM returns per-quadrant pixel
// pairs, and each scenario task compares observed timing, addresses and thresholds to hand-computed values.
module tb_binarize_frame_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [19:0] i_begin_addr;
    logic [7:0]  i_offset;
    logic [15:0] i_sram_rdata;
    logic [19:0] o_sram_addr;
    logic [19:0] i_conv_sram_addr;
    logic        o_conv_start;
    logic        i_conv_finished;
    logic [7:0]  o_threshold1, o_threshold2, o_threshold3, o_threshold4;
    logic        o_busy;
    logic        o_done;

    int checks   = 0;
    int failures = 0;

    logic [19:0] tb_base;
    logic [7:0]  pix_hi [4];
    logic [7:0]  pix_lo [4];
    logic [19:0] rel;
    logic [1:0]  rq;
    logic [31:0] thr_all;

    int          conv_cyc, done_cyc, done_cnt, cs_cnt, addr_err, busy_err, thr_chg;
    logic [31:0] thr_snap;

    binarize_frame_ctrl dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_start          (i_start),
        .i_begin_addr     (i_begin_addr),
        .i_offset         (i_offset),
        .i_sram_rdata     (i_sram_rdata),
        .o_sram_addr      (o_sram_addr),
        .i_conv_sram_addr (i_conv_sram_addr),
        .o_conv_start     (o_conv_start),
        .i_conv_finished  (i_conv_finished),
        .o_threshold1     (o_threshold1),
        .o_threshold2     (o_threshold2),
        .o_threshold3     (o_threshold3),
        .o_threshold4     (o_threshold4),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    always #5 i_clk = ~i_clk;

    assign thr_all = {o_threshold1, o_threshold2, o_threshold3, o_threshold4};

    // Combinational SRAM: word at (row, col) of the frame based at tb_base holds its quadrant's pixel pair.
    always_comb begin
        rel = o_sram_addr - tb_base;
        rq  = {(rel / 20'd80) >= 20'd80, (rel % 20'd80) >= 20'd40};
        i_sram_rdata = (rel < 20'd12800) ? {pix_hi[rq], pix_lo[rq]} : 16'hFFFF;
    end

    task automatic set_pixels(input logic [63:0] pairs);
        for (int q = 0; q < 4; q++) begin
            pix_hi[q] = pairs[63 - 16*q -: 8];
            pix_lo[q] = pairs[55 - 16*q -: 8];
        end
    endtask

    // Runs one frame from the i_start cycle (cycle 0) and records what it observed per cycle.
    task automatic run_frame(input logic [19:0] base, input logic [7:0] off,
                             input int fin_delay, input bit glitch);
        int n;
        tb_base = base; i_begin_addr = base; i_offset = off;
        i_conv_finished = (fin_delay == 0);
        conv_cyc = -1; done_cyc = -1; done_cnt = 0; cs_cnt = 0;
        addr_err = 0; busy_err = 0; thr_chg = 0; thr_snap = '0;
        @(negedge i_clk);
        i_start = 1'b1;
        n = 0;
        while (n < 30000) begin
            @(negedge i_clk);
            n++;
            i_start = 1'b0;
            if (n <= 12800) begin
                if (o_sram_addr !== base + 20'(n - 1)) addr_err++;
            end else if (conv_cyc < 0 && !o_conv_start) begin
                if (o_sram_addr !== 20'd0) addr_err++;
            end
            if (o_conv_start) begin
                cs_cnt++;
                if (conv_cyc < 0) begin
                    conv_cyc = n;
                    thr_snap = thr_all;
                end
            end
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (conv_cyc > 0 && done_cyc < 0) begin
                if (o_sram_addr !== i_conv_sram_addr) addr_err++;
                if (thr_all !== thr_snap) thr_chg++;
            end
            if (done_cyc > 0) begin
                if (o_busy !== 1'b0) busy_err++;
                if (o_sram_addr !== 20'd0) addr_err++;
            end else if (o_busy !== 1'b1) begin
                busy_err++;
            end
            if (done_cyc > 0 && n >= done_cyc + 20) break;
            i_conv_sram_addr = 20'h80000 ^ 20'(n * 7);
            if (glitch && (n == 100 || (conv_cyc > 0 && n == conv_cyc + 1))) i_start = 1'b1;
            if (fin_delay > 0 && conv_cyc > 0 && n == conv_cyc + fin_delay) i_conv_finished = 1'b1;
            if (done_cyc > 0) i_conv_finished = 1'b0;
        end
        i_start = 1'b0;
        i_conv_finished = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_start = 1'b0; i_begin_addr = 20'h12345; i_offset = 8'h00;
        i_conv_sram_addr = 20'hABCDE; i_conv_finished = 1'b0; tb_base = '0;
        set_pixels(64'h0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", o_done); end
        checks++; if (o_conv_start !== 1'b0) begin failures++; $display("FAIL reset_conv_start got=%b exp=0", o_conv_start); end
        checks++; if (o_sram_addr !== 20'd0) begin failures++; $display("FAIL reset_addr got=%h exp=00000", o_sram_addr); end
        checks++; if (thr_all !== 32'h80808080) begin failures++; $display("FAIL reset_thr got=%h exp=80808080", thr_all); end
    endtask

    // Uniform 100, offset 0, finished held high, stray starts in SCAN and CONV_WAIT.
    task automatic test_basic();
        set_pixels({4{16'h6464}});
        run_frame(20'h00100, 8'h00, 0, 1'b1);
        checks++; if (conv_cyc !== 12885) begin failures++; $display("FAIL basic_latency got=%0d exp=12885", conv_cyc); end
        checks++; if (addr_err !== 0) begin failures++; $display("FAIL basic_addr errors=%0d exp=0", addr_err); end
        checks++; if (thr_all !== 32'h64646464) begin failures++; $display("FAIL basic_thr got=%h exp=64646464", thr_all); end
        checks++; if (done_cyc !== conv_cyc + 3) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=%0d", done_cyc, conv_cyc + 3); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
        checks++; if (cs_cnt !== 1) begin failures++; $display("FAIL basic_conv_start_count got=%0d exp=1", cs_cnt); end
        checks++; if (busy_err !== 0) begin failures++; $display("FAIL basic_busy errors=%0d exp=0", busy_err); end
    endtask

    // Distinct quadrants, offset +5, converter finishing 12800 cycles after start.
    task automatic test_quadrants();
        set_pixels({16'h0A0A, 16'h3C3C, 16'h7878, 16'hC8C8});
        run_frame(20'h40000, 8'h05, 12800, 1'b0);
        checks++; if (conv_cyc !== 12885) begin failures++; $display("FAIL quad_latency got=%0d exp=12885", conv_cyc); end
        checks++; if (thr_all !== 32'h0F417DCD) begin failures++; $display("FAIL quad_thr got=%h exp=0f417dcd", thr_all); end
        checks++; if (thr_chg !== 0) begin failures++; $display("FAIL quad_thr_stable changes=%0d exp=0", thr_chg); end
        checks++; if (addr_err !== 0) begin failures++; $display("FAIL quad_addr_mux errors=%0d exp=0", addr_err); end
        checks++; if (done_cyc !== conv_cyc + 12801) begin failures++; $display("FAIL quad_done_cycle got=%0d exp=%0d", done_cyc, conv_cyc + 12801); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL quad_done_count got=%0d exp=1", done_cnt); end
    endtask

    // Offset +20: TL 100/101 floors to 100 (->120), TR 250 clamps, BL 235.5 lands on 255, BR 0 -> 20.
    task automatic test_saturation_high();
        set_pixels({16'h6465, 16'hFAFA, 16'hECEB, 16'h0000});
        run_frame(20'hFC000, 8'h14, 0, 1'b0);
        checks++; if (thr_all !== 32'h78FFFF14) begin failures++; $display("FAIL sat_high_thr got=%h exp=78ffff14", thr_all); end
        checks++; if (addr_err !== 0) begin failures++; $display("FAIL sat_high_addr errors=%0d exp=0", addr_err); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL sat_high_done_count got=%0d exp=1", done_cnt); end
    endtask

    // Reset at scan word 5000 of a frame; outputs return to reset values at once, no o_done.
    task automatic test_reset_mid_scan();
        int n;
        bit saw_done;
        set_pixels({4{16'h0505}});
        tb_base = 20'h00000; i_begin_addr = 20'h00000; i_offset = 8'hEC;
        saw_done = 1'b0;
        @(negedge i_clk);
        i_start = 1'b1;
        for (n = 1; n <= 5001; n++) begin
            @(negedge i_clk);
            i_start = 1'b0;
        end
        checks++; if (o_sram_addr !== 20'd5000) begin failures++; $display("FAIL midrst_word_addr got=%h exp=01388", o_sram_addr); end
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", o_busy); end
        checks++; if (o_sram_addr !== 20'd0) begin failures++; $display("FAIL midrst_addr got=%h exp=00000", o_sram_addr); end
        checks++; if (o_conv_start !== 1'b0) begin failures++; $display("FAIL midrst_conv_start got=%b exp=0", o_conv_start); end
        checks++; if (thr_all !== 32'h80808080) begin failures++; $display("FAIL midrst_thr got=%h exp=80808080", thr_all); end
        repeat (2) begin
            @(negedge i_clk);
            if (o_done) saw_done = 1'b1;
        end
        i_rst_n = 1'b1;
        repeat (3) begin
            @(negedge i_clk);
            if (o_done) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL midrst_no_done got=%b exp=0", saw_done); end
    endtask

    // Frame right after the mid-scan reset: all 5 with offset -20 clamps to 0.
    task automatic test_saturation_low();
        set_pixels({4{16'h0505}});
        run_frame(20'h00000, 8'hEC, 0, 1'b0);
        checks++; if (conv_cyc !== 12885) begin failures++; $display("FAIL sat_low_latency got=%0d exp=12885", conv_cyc); end
        checks++; if (thr_all !== 32'h00000000) begin failures++; $display("FAIL sat_low_thr got=%h exp=00000000", thr_all); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL sat_low_done_count got=%0d exp=1", done_cnt); end
        checks++; if (busy_err !== 0) begin failures++; $display("FAIL sat_low_busy errors=%0d exp=0", busy_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_quadrants();
        test_saturation_high();
        test_reset_mid_scan();
        test_saturation_low();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
